mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the miniRV-1 pipeline, directly downstream of the EX/MEM register. It formats stores (byte enables, lane replication) and loads (lane extraction, sign/zero extension) against a valid/grant data-memory bus, stalls the pipeline while a bus transaction is outstanding, selects the writeback value, and registers the result as the MEM/WB register feeding writeback and forwarding.

## Interface
- No parameters; widths fixed at 32-bit data/address, 5-bit register index.
- clk_i  in  1  rising-edge clock
- rst_i  in  1  asynchronous, active-high reset
- alu_c_i, rD2_i, pc4_i, pcimm_i, imm_i  in  32 each  EX/MEM payload (alu_c_i = address for memory ops, rD2_i = store data)
- wR_i  in  5  destination register
- mask_op_i  in  2  access size: 0 byte, 1 half, 2 word, 3 reserved (treated as word)
- mask_sign_i  in  1  1 = sign-extend load
- dram_we_i  in  1  store
- wb_sel_i  in  3  0 ALU, 1 DRAM (load), 2 PC+4, 3 imm, 4 pcimm; others -> ALU
- rf_we_i, null_i  in  1 each  writeback enable; bubble marker
- dm_req_o  out  1  bus request
- dm_we_o  out  1  write request
- dm_addr_o  out  32  {alu_c_i[31:2], 2'b00}
- dm_be_o  out  4  byte enables (0000 for loads)
- dm_wdata_o  out  32  lane-replicated store data
- dm_gnt_i  in  1  request accepted this cycle
- dm_rvalid_i  in  1  load data valid (earliest one cycle after grant)
- dm_rdata_i  in  32  load word
- stall_o  out  1  hold PC/IF/ID/EX/EX-MEM this cycle
- wR_o, wD_o  out  5, 32  MEM/WB destination and data
- rf_we_o, null_o  out  1 each  MEM/WB write enable, bubble marker
- misalign_o  out  1  registered one-cycle flag: misaligned access dropped

## Operation
- Memory op = ~null_i & (dram_we_i | wb_sel_i==1). Misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
- Misaligned op: no bus request, no stall; MEM/WB captures bubble (rf_we_o=0, null_o=1), misalign_o=1 next cycle.
- FSM states IDLE, REQ, WAIT.
  - IDLE/REQ: dm_req_o=1 for aligned memory op. Store+gnt -> IDLE, completes. Load+gnt -> WAIT. No gnt -> REQ.
  - WAIT: dm_req_o=0; on dm_rvalid_i, load completes, -> IDLE. dm_rvalid_i ignored outside WAIT.
- stall_o = aligned memory op & ~(store & gnt in IDLE/REQ) & ~(WAIT & rvalid). Combinational.
- Upstream holds all inputs stable while stall_o=1; the block relies on this.
- Store formatting: byte -> wdata {4{rD2[7:0]}}, be 0001<<addr[1:0]; half -> {2{rD2[15:0]}}, be 0011<<addr[1:0]; word -> rD2, be 1111.
- Load formatting: rdata >> 8*addr[1:0], then take 8/16/32 bits, extend per mask_sign_i.
- MEM/WB register, updated every edge: if stall_o=1 capture bubble (wR 0, wD 0, rf_we 0, null 1); else capture wR_i, selected wD, rf_we_i & ~null_i, null_i.

## Timing
- Reset: state IDLE, wR_o 0, wD_o 0, rf_we_o 0, null_o 1, misalign_o 0; dm_req_o 0 while reset asserted.
- Non-memory op: result on MEM/WB outputs one cycle after input presented.
- Store with immediate gnt: zero stall cycles, 1-cycle latency. Each cycle without gnt adds one stall cycle.
- Load with immediate gnt and rvalid next cycle: one stall cycle, result valid two cycles after presentation.
- Reset mid-transaction: FSM to IDLE at once; a late dm_rvalid_i is discarded.
- Back-to-back memory ops: new request may issue in the cycle following completion.

## Structure
- Shared package miniRV_pkg: wb_sel encodings, mask_op encodings, mem FSM state enum.
- One sub-module mem_align: purely combinational store lane/byte-enable generation and load extract/extend; the FSM and MEM/WB register stay in mem_access.

## Test plan
- ALU op, alu_c_i=0x1234, wb_sel 0, rf_we 1 -> next cycle wD_o=0x1234, rf_we_o=1, stall_o never high.
- Store byte rD2=0xAABBCCDD, addr 0x103, gnt immediate -> dm_be_o=1000, dm_wdata_o=0xDDDDDDDD, dm_addr_o=0x100, no stall.
- Load half signed addr 0x102, rdata 0x8001xxxx, gnt cycle 0, rvalid cycle 2 -> stall_o high cycles 0-1, bubble on MEM/WB twice, then wD_o=0xFFFF8001.
- Load word addr 0x101 -> no dm_req_o, no stall, rf_we_o=0, misalign_o=1 for one cycle.
- Store with gnt withheld 3 cycles -> dm_req_o held, stall_o high 3 cycles, completes on 4th.
- rst_i asserted while in WAIT, then rvalid pulses -> outputs at reset values, FSM IDLE, pulse ignored.

Source files
------------

// File: rtl/miniRV_pkg.sv
// miniRV_pkg: shared encodings for the miniRV-1 memory stage
package miniRV_pkg;
    localparam logic [2:0] WB_DRAM  = 3'd1;
    localparam logic [2:0] WB_PC4   = 3'd2;
    localparam logic [2:0] WB_IMM   = 3'd3;
    localparam logic [2:0] WB_PCIMM = 3'd4;
    localparam logic [1:0] MASK_B   = 2'd0;
    localparam logic [1:0] MASK_H   = 2'd1;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
endpackage

// File: rtl/mem_align.sv
// mem_align: store lane replication/byte enables and load extract/extend
module mem_align
    import miniRV_pkg::*;
(
    input  logic [1:0]  mask_op_i,
    input  logic        mask_sign_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o,
    output logic        misalign_o
);
    logic [31:0] sh;
    logic        is_b, is_h;
    // Reserved size code falls through to word handling
    always_comb begin
        is_b = mask_op_i == MASK_B;
        is_h = mask_op_i == MASK_H;
        sh = ld_word_i >> {off_i, 3'b000};
        misalign_o = is_h ? off_i[0] : ~is_b & (off_i != 2'b00);
        be_o = is_b ? 4'b0001 << off_i : is_h ? 4'b0011 << off_i : 4'b1111;
        wdata_o = is_b ? {4{st_data_i[7:0]}} : is_h ? {2{st_data_i[15:0]}} : st_data_i;
        ld_data_o = is_b ? {{24{mask_sign_i & sh[7]}}, sh[7:0]} :
                    is_h ? {{16{mask_sign_i & sh[15]}}, sh[15:0]} : sh;
    end
endmodule

// File: rtl/mem_access.sv
// mem_access: miniRV-1 memory stage with bus handshake, stall and MEM/WB register
module mem_access
    import miniRV_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] alu_c_i,
    input  logic [31:0] rD2_i,
    input  logic [31:0] pc4_i,
    input  logic [31:0] pcimm_i,
    input  logic [31:0] imm_i,
    input  logic [4:0]  wR_i,
    input  logic [1:0]  mask_op_i,
    input  logic        mask_sign_i,
    input  logic        dram_we_i,
    input  logic [2:0]  wb_sel_i,
    input  logic        rf_we_i,
    input  logic        null_i,
    output logic        dm_req_o,
    output logic        dm_we_o,
    output logic [31:0] dm_addr_o,
    output logic [3:0]  dm_be_o,
    output logic [31:0] dm_wdata_o,
    input  logic        dm_gnt_i,
    input  logic        dm_rvalid_i,
    input  logic [31:0] dm_rdata_i,
    output logic        stall_o,
    output logic [4:0]  wR_o,
    output logic [31:0] wD_o,
    output logic        rf_we_o,
    output logic        null_o,
    output logic        misalign_o
);
    logic [1:0]  state, state_d;
    logic [3:0]  be;
    logic [31:0] ld_data, wd_sel;
    logic        mis, mem_op, op_ok, in_wait, st_done, ld_done, drop, bub;

    mem_align u_align (
        .mask_op_i   (mask_op_i),
        .mask_sign_i (mask_sign_i),
        .off_i       (alu_c_i[1:0]),
        .st_data_i   (rD2_i),
        .ld_word_i   (dm_rdata_i),
        .be_o        (be),
        .wdata_o     (dm_wdata_o),
        .ld_data_o   (ld_data),
        .misalign_o  (mis)
    );

    assign dm_addr_o = {alu_c_i[31:2], 2'b00};

    // Bus request, stall and next state; rvalid only counts while waiting for load data
    always_comb begin
        mem_op = ~null_i & (dram_we_i | (wb_sel_i == WB_DRAM));
        drop = mem_op & mis;
        op_ok = mem_op & ~mis & ~rst_i;
        in_wait = state == ST_WAIT;
        st_done = ~in_wait & dram_we_i & dm_gnt_i;
        ld_done = in_wait & dm_rvalid_i;
        dm_req_o = op_ok & ~in_wait;
        dm_we_o = dm_req_o & dram_we_i;
        dm_be_o = dram_we_i ? be : 4'b0000;
        stall_o = op_ok & ~st_done & ~ld_done;
        bub = stall_o | drop;
        state_d = in_wait ? (dm_rvalid_i ? ST_IDLE : ST_WAIT) :
                  ~op_ok ? ST_IDLE : ~dm_gnt_i ? ST_REQ : dram_we_i ? ST_IDLE : ST_WAIT;
        wd_sel = wb_sel_i == WB_DRAM ? ld_data : wb_sel_i == WB_PC4 ? pc4_i :
                 wb_sel_i == WB_IMM ? imm_i : wb_sel_i == WB_PCIMM ? pcimm_i : alu_c_i;
    end

    // Handshake state; reset abandons any outstanding access
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else state <= state_d;
    end

    // MEM/WB register: bubbles while stalled or when a misaligned access is dropped
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wR_o <= 5'd0;
            wD_o <= 32'd0;
            rf_we_o <= 1'b0;
            null_o <= 1'b1;
            misalign_o <= 1'b0;
        end else begin
            wR_o <= bub ? 5'd0 : wR_i;
            wD_o <= bub ? 32'd0 : wd_sel;
            rf_we_o <= ~bub & rf_we_i & ~null_i;
            null_o <= bub | null_i;
            misalign_o <= drop;
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized scoreboard bench for mem_access
module tb_mem_access;
    logic        clk_i = 0, rst_i = 1;
    logic [31:0] alu_c_i = 0, rD2_i = 0, pc4_i = 0, pcimm_i = 0, imm_i = 0;
    logic [4:0]  wR_i = 0;
    logic [1:0]  mask_op_i = 0;
    logic        mask_sign_i = 0, dram_we_i = 0, rf_we_i = 0, null_i = 1;
    logic [2:0]  wb_sel_i = 0;
    logic        dm_req_o, dm_we_o, dm_gnt_i = 0, dm_rvalid_i = 0;
    logic [31:0] dm_addr_o, dm_wdata_o, dm_rdata_i = 0;
    logic [3:0]  dm_be_o;
    logic        stall_o, rf_we_o, null_o, misalign_o;
    logic [4:0]  wR_o;
    logic [31:0] wD_o;

    typedef struct { logic [4:0] wr; logic [31:0] wd; logic we; } exp_t;
    exp_t exp_q[$];
    int   mis_q[$];
    int   errors = 0, checks = 0;
    logic [7:0] bus_mem[256];
    logic [7:0] ref_mem[256];

    always #5 clk_i = ~clk_i;

    mem_access dut (
        .clk_i(clk_i), .rst_i(rst_i), .alu_c_i(alu_c_i), .rD2_i(rD2_i), .pc4_i(pc4_i),
        .pcimm_i(pcimm_i), .imm_i(imm_i), .wR_i(wR_i), .mask_op_i(mask_op_i),
        .mask_sign_i(mask_sign_i), .dram_we_i(dram_we_i), .wb_sel_i(wb_sel_i),
        .rf_we_i(rf_we_i), .null_i(null_i), .dm_req_o(dm_req_o), .dm_we_o(dm_we_o),
        .dm_addr_o(dm_addr_o), .dm_be_o(dm_be_o), .dm_wdata_o(dm_wdata_o),
        .dm_gnt_i(dm_gnt_i), .dm_rvalid_i(dm_rvalid_i), .dm_rdata_i(dm_rdata_i),
        .stall_o(stall_o), .wR_o(wR_o), .wD_o(wD_o), .rf_we_o(rf_we_o),
        .null_o(null_o), .misalign_o(misalign_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [1:0] mop);
        return mop == 2'd0 ? 1 : mop == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] mop, input logic sgn);
        int n = size_of(mop);
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v += 32'(ref_mem[8'(a[7:0] + 8'(i))]) << (8 * i);
        if (sgn && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    function automatic logic [31:0] ref_wd(input logic [2:0] sel, input logic [31:0] alu, pc4, imm, pcimm, ld);
        case (sel)
            3'd1: return ld;
            3'd2: return pc4;
            3'd3: return imm;
            3'd4: return pcimm;
            default: return alu;
        endcase
    endfunction

    // Issues one EX/MEM payload, plays the memory bus, and queues the expected MEM/WB result
    task automatic op(input logic we, input logic [2:0] sel, input logic [1:0] mop, input logic sgn,
                      input logic nul, input logic rfwe, input logic [31:0] addr, input logic [31:0] data,
                      input int gd, input int rd);
        int n = size_of(mop);
        logic mem = !nul && (we || sel == 3'd1);
        logic mis = (int'(addr[1:0]) % n) != 0;
        logic [7:0] b = addr[7:0] & 8'hFC;
        logic [31:0] exp_wdata;
        exp_t e;
        alu_c_i = addr; rD2_i = data; pc4_i = $urandom; imm_i = $urandom; pcimm_i = $urandom;
        wR_i = 5'($urandom); mask_op_i = mop; mask_sign_i = sgn; dram_we_i = we; wb_sel_i = sel;
        rf_we_i = rfwe; null_i = nul; dm_gnt_i = 0; dm_rvalid_i = 0;
        e.wr = wR_i; e.we = rfwe;
        exp_wdata = mop == 2'd0 ? 32'(data[7:0]) * 32'h01010101 :
                    mop == 2'd1 ? 32'(data[15:0]) * 32'h00010001 : data;
        if (!mem || mis) begin
            #1;
            chk("req_idle", 32'(dm_req_o), 0);
            chk("stall_idle", 32'(stall_o), 0);
            if (mem) mis_q.push_back(1);
            else if (!nul) begin
                e.wd = ref_wd(sel, addr, pc4_i, imm_i, pcimm_i, 0);
                exp_q.push_back(e);
            end
            @(posedge clk_i); #1;
            return;
        end
        for (int k = 0; k <= gd; k++) begin
            dm_gnt_i = (k == gd);
            #1;
            chk("req", 32'(dm_req_o), 1);
            chk("we", 32'(dm_we_o), 32'(we));
            chk("addr", dm_addr_o, addr & ~32'd3);
            chk("stall_req", 32'(stall_o), 32'(!(we && k == gd)));
            if (we) begin
                chk("be", 32'(dm_be_o), 32'(((1 << n) - 1) << addr[1:0]));
                chk("wdata", dm_wdata_o, exp_wdata);
                if (k == gd)
                    for (int i = 0; i < 4; i++)
                        if (dm_be_o[i]) bus_mem[8'(dm_addr_o[7:0] + 8'(i))] = dm_wdata_o[8*i+:8];
            end else chk("be_load", 32'(dm_be_o), 0);
            @(posedge clk_i); #1;
        end
        dm_gnt_i = 0;
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[8'(addr[7:0] + 8'(i))] = data[8*i+:8];
            e.wd = ref_wd(sel, addr, pc4_i, imm_i, pcimm_i, 0);
            exp_q.push_back(e);
        end else begin
            e.wd = ref_wd(sel, addr, pc4_i, imm_i, pcimm_i, ref_load(addr, mop, sgn));
            exp_q.push_back(e);
            for (int j = 1; j <= rd; j++) begin
                dm_rvalid_i = (j == rd);
                dm_rdata_i = (j == rd) ? {bus_mem[b+3], bus_mem[b+2], bus_mem[b+1], bus_mem[b]} : $urandom;
                #1;
                chk("req_wait", 32'(dm_req_o), 0);
                chk("stall_wait", 32'(stall_o), 32'(j != rd));
                @(posedge clk_i); #1;
            end
            dm_rvalid_i = 0;
        end
    endtask

    // Monitor: every non-bubble MEM/WB output must match the next queued expectation
    always @(negedge clk_i) begin
        exp_t e;
        if (!null_o) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result: got wD=%h expected no result", wD_o);
            end else begin
                e = exp_q.pop_front();
                chk("wR", 32'(wR_o), 32'(e.wr));
                chk("wD", wD_o, e.wd);
                chk("rf_we", 32'(rf_we_o), 32'(e.we));
            end
        end else chk("bubble_we", 32'(rf_we_o), 0);
        if (misalign_o) begin
            checks++;
            if (mis_q.size() == 0) begin
                errors++;
                $display("FAIL misalign_flag: got 1 expected 0");
            end else void'(mis_q.pop_front());
        end
    end

    initial begin
        logic [2:0] sel;
        int kind;
        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = 8'($urandom);
            ref_mem[i] = bus_mem[i];
        end
        alu_c_i = 32'h104; wb_sel_i = 3'd1; null_i = 0; mask_op_i = 2'd2;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_wR", 32'(wR_o), 0);
        chk("rst_wD", wD_o, 0);
        chk("rst_rf_we", 32'(rf_we_o), 0);
        chk("rst_null", 32'(null_o), 1);
        chk("rst_misalign", 32'(misalign_o), 0);
        chk("rst_req", 32'(dm_req_o), 0);
        null_i = 1;
        @(posedge clk_i); #1;
        rst_i = 0;
        @(posedge clk_i); #1;

        op(0, 3'd0, 2'd2, 0, 0, 1, 32'h1234, 32'h0, 0, 0);
        op(1, 3'd0, 2'd0, 0, 0, 0, 32'h103, 32'hAABBCCDD, 0, 0);
        bus_mem[8'h02] = 8'h01; ref_mem[8'h02] = 8'h01;
        bus_mem[8'h03] = 8'h80; ref_mem[8'h03] = 8'h80;
        op(0, 3'd1, 2'd1, 1, 0, 1, 32'h102, 32'h0, 0, 2);
        op(0, 3'd1, 2'd2, 0, 0, 1, 32'h101, 32'h0, 0, 1);
        op(1, 3'd3, 2'd2, 0, 0, 1, 32'h108, 32'h5A5A1234, 3, 0);

        alu_c_i = 32'h104; wb_sel_i = 3'd1; dram_we_i = 0; null_i = 0;
        mask_op_i = 2'd2; rf_we_i = 1; wR_i = 5'd5; dm_gnt_i = 1;
        #1; chk("rst_tx_req", 32'(dm_req_o), 1);
        @(posedge clk_i); #1;
        dm_gnt_i = 0;
        #1; chk("rst_tx_wait_stall", 32'(stall_o), 1);
        rst_i = 1;
        #1;
        chk("midrst_null", 32'(null_o), 1);
        chk("midrst_wD", wD_o, 0);
        chk("midrst_stall", 32'(stall_o), 0);
        chk("midrst_req", 32'(dm_req_o), 0);
        dm_rvalid_i = 1; dm_rdata_i = $urandom;
        @(posedge clk_i); #1;
        null_i = 1; wb_sel_i = 3'd0; alu_c_i = 0; wR_i = 0; rst_i = 0;
        #1; chk("late_rvalid_req", 32'(dm_req_o), 0);
        @(posedge clk_i); #1;
        dm_rvalid_i = 0;
        chk("late_rvalid_null", 32'(null_o), 1);
        chk("late_rvalid_wD", wD_o, 0);
        op(0, 3'd1, 2'd2, 0, 0, 1, 32'h104, 32'h0, 0, 1);

        for (int t = 0; t < 300; t++) begin
            kind = $urandom_range(0, 2);
            sel = 3'($urandom_range(0, 6));
            if (sel != 3'd0) sel = sel + 3'd1;
            if (kind == 2) sel = 3'd1;
            op(kind == 1, sel, 2'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 7) == 0,
               1'($urandom), 32'h100 | 32'($urandom_range(0, 255)), $urandom,
               $urandom_range(0, 3), $urandom_range(1, 3));
        end
        null_i = 1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("mis_q_drained", mis_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
